// File: rtl/picosoc_bus_arbiter.sv
// picosoc_bus_arbiter
// Two-master, one-slave arbiter for the PicoRV32 native memory bus.
// The owner's request is forwarded combinationally. The owner's ready and
// rdata come straight back from the slave. Ties between masters alternate
// through a last_owner register.
//
// Optional feature: define PICOSOC_ARB_TIMEOUT_EN to add a 16-bit grant
// watchdog. When the slave stalls for TIMEOUT_CYCLES granted cycles, the
// arbiter completes the transfer itself: the owner gets one ready pulse with
// rdata 32'hDEAD_BEEF, and the sticky timeout_err flag is set.
// Without the macro there is no counter, timeout_err is 0, and a grant is
// held until the slave answers or the owner drops its request.

module picosoc_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam logic [31:0] TIMEOUT_RDATA_C = 32'hDEAD_BEEF;

    // Out-of-range watchdog lengths are rejected at elaboration time.
    if ((TIMEOUT_CYCLES < 32'd2) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
        $error("picosoc_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    // The state encoding matches the one-hot grant output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t      state_r;
    logic        last_owner_r;     // 1: m1 was served last, so m0 wins the next tie

    logic        own_valid_s;
    logic        own_instr_s;
    logic [31:0] own_addr_s;
    logic [31:0] own_wdata_s;
    logic [3:0]  own_wstrb_s;
    logic        timeout_hit_s;    // watchdog completes the current transfer this cycle
    logic        err_flag_s;

    // Select the request fields of whichever master currently owns the bus.
    always_comb begin
        own_valid_s = 1'b0;
        own_instr_s = 1'b0;
        own_addr_s  = 32'h0000_0000;
        own_wdata_s = 32'h0000_0000;
        own_wstrb_s = 4'b0000;
        case (state_r)
            GNT0: begin
                own_valid_s = m0_valid;
                own_instr_s = m0_instr;
                own_addr_s  = m0_addr;
                own_wdata_s = m0_wdata;
                own_wstrb_s = m0_wstrb;
            end
            GNT1: begin
                own_valid_s = m1_valid;
                own_instr_s = m1_instr;
                own_addr_s  = m1_addr;
                own_wdata_s = m1_wdata;
                own_wstrb_s = m1_wstrb;
            end
            default: begin
                own_valid_s = 1'b0;
                own_instr_s = 1'b0;
                own_addr_s  = 32'h0000_0000;
                own_wdata_s = 32'h0000_0000;
                own_wstrb_s = 4'b0000;
            end
        endcase
    end

`ifdef PICOSOC_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST_C = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] to_cnt_r;
    logic        timeout_err_r;

    // The last allowed stalled cycle of a live grant turns into a forced completion.
    assign timeout_hit_s = (state_r != IDLE) && own_valid_s && !s_ready && (to_cnt_r == TO_LAST_C);
    assign err_flag_s    = timeout_err_r;

    // Count stalled granted cycles. The count stays at zero in IDLE, so every grant starts from 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r      <= 16'd0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                to_cnt_r <= 16'd0;
            end else if (!s_ready) begin
                to_cnt_r <= to_cnt_r + 16'd1;
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign err_flag_s    = 1'b0;
`endif

    // Arbitration FSM: alternate on ties and release the bus on completion, a dropped request or a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (m0_valid && m1_valid) begin
                        state_r <= last_owner_r ? GNT0 : GNT1;
                    end else if (m0_valid) begin
                        state_r <= GNT0;
                    end else if (m1_valid) begin
                        state_r <= GNT1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT0: begin
                    if (s_ready || timeout_hit_s) begin
                        state_r      <= IDLE;
                        last_owner_r <= 1'b0;
                    end else if (!m0_valid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= GNT0;
                    end
                end
                GNT1: begin
                    if (s_ready || timeout_hit_s) begin
                        state_r      <= IDLE;
                        last_owner_r <= 1'b1;
                    end else if (!m1_valid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= GNT1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    last_owner_r <= last_owner_r;
                end
            endcase
        end
    end

    // Drive the slave request and master responses. While reset is high, every output is held at 0.
    always_comb begin
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = 32'h0000_0000;
        s_wdata  = 32'h0000_0000;
        s_wstrb  = 4'b0000;
        m0_ready = 1'b0;
        m0_rdata = 32'h0000_0000;
        m1_ready = 1'b0;
        m1_rdata = 32'h0000_0000;
        grant    = 2'b00;
        if (!reset) begin
            s_valid = own_valid_s && !timeout_hit_s;
            s_instr = own_instr_s;
            s_addr  = own_addr_s;
            s_wdata = own_wdata_s;
            s_wstrb = own_wstrb_s;
            grant   = state_r;
            case (state_r)
                GNT0: begin
                    m0_ready = s_ready || timeout_hit_s;
                    m0_rdata = timeout_hit_s ? TIMEOUT_RDATA_C : s_rdata;
                end
                GNT1: begin
                    m1_ready = s_ready || timeout_hit_s;
                    m1_rdata = timeout_hit_s ? TIMEOUT_RDATA_C : s_rdata;
                end
                default: begin
                    m0_ready = 1'b0;
                    m1_ready = 1'b0;
                end
            endcase
        end else begin
            grant = 2'b00;
        end
    end

    assign timeout_err = err_flag_s && !reset;

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Self-checking bench for picosoc_bus_arbiter. A transaction-level model
// tracks who owns the bus, who won last, and how long the current grant has
// lasted. Every output is compared each cycle under directed and random
// stimulus. Watchdog expectations follow PICOSOC_ARB_TIMEOUT_EN.

module tb_picosoc_bus_arbiter;

    localparam int TB_TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mv[2];
    logic        mi[2];
    logic [31:0] ma[2];
    logic [31:0] mw[2];
    logic [3:0]  ms[2];
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    // Reference model: -1 idle, else the master index that owns the bus.
    int own_m;
    int last_m;
    int gcyc;
    bit err_m;
    bit done[2];
    int total_cnt = 0;
    int bad_cnt   = 0;
    int rdy0_cnt  = 0;

    always #5 clk = ~clk;

    picosoc_bus_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(mv[0]), .m0_instr(mi[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(mv[1]), .m1_instr(mi[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s at %0t: got=%h want=%h", tag, $time, obs, exp_v);
        end
    endtask

    // One bus cycle: compare outputs against the model, advance the model, then move to the next negedge.
    task automatic step();
        logic        e_valid, e_instr, e_err, own_v, to;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_grant;
        logic        e_rdy[2];
        logic [31:0] e_rd[2];
        #1;
        e_valid = 1'b0; e_instr = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
        e_grant = 2'b00; e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_rd[0] = 32'h0; e_rd[1] = 32'h0;
        own_v = 1'b0; to = 1'b0;
        if (!reset && own_m >= 0) begin
            own_v = mv[own_m];
`ifdef PICOSOC_ARB_TIMEOUT_EN
            to = own_v && !s_ready && (gcyc + 1 == TB_TO);
`endif
            e_valid = own_v && !to;
            e_instr = mi[own_m];
            e_addr  = ma[own_m];
            e_wdata = mw[own_m];
            e_wstrb = ms[own_m];
            e_grant = (own_m == 0) ? 2'b01 : 2'b10;
            e_rdy[own_m] = s_ready || to;
            e_rd[own_m]  = to ? 32'hDEAD_BEEF : s_rdata;
        end
        e_err = reset ? 1'b0 : err_m;
        check_eq("grant",    32'(grant),    32'(e_grant));
        check_eq("s_valid",  32'(s_valid),  32'(e_valid));
        check_eq("s_instr",  32'(s_instr),  32'(e_instr));
        check_eq("s_addr",   s_addr,        e_addr);
        check_eq("s_wdata",  s_wdata,       e_wdata);
        check_eq("s_wstrb",  32'(s_wstrb),  32'(e_wstrb));
        check_eq("m0_ready", 32'(m0_ready), 32'(e_rdy[0]));
        check_eq("m1_ready", 32'(m1_ready), 32'(e_rdy[1]));
        check_eq("m0_rdata", m0_rdata,      e_rd[0]);
        check_eq("m1_rdata", m1_rdata,      e_rd[1]);
        check_eq("timeout_err", 32'(timeout_err), 32'(e_err));
        if (m0_ready) rdy0_cnt++;
        for (int m = 0; m < 2; m++) if (e_rdy[m]) done[m] = 1'b1;
        // Model state update at the coming edge.
        if (reset) begin
            own_m = -1; last_m = 1; err_m = 1'b0; gcyc = 0;
            done[0] = 1'b0; done[1] = 1'b0;
        end else if (own_m < 0) begin
            gcyc = 0;
            if (mv[0] && mv[1]) own_m = (last_m == 1) ? 0 : 1;
            else if (mv[0])     own_m = 0;
            else if (mv[1])     own_m = 1;
            else                own_m = -1;
        end else if (s_ready || to) begin
            if (to) err_m = 1'b1;
            last_m = own_m;
            own_m  = -1;
        end else if (!own_v) begin
            own_m = -1;
        end else begin
            gcyc++;
        end
        @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            if (done[m]) begin
                mv[m]   = 1'b0;
                done[m] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] st);
        mv[m] = 1'b1; ma[m] = a; mw[m] = w; ms[m] = st; mi[m] = 1'b0;
    endtask

    initial begin
        int base;
        own_m = -1; last_m = 1; gcyc = 0; err_m = 1'b0;
        done[0] = 1'b0; done[1] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; mi[m] = 1'b0; ma[m] = 32'h0; mw[m] = 32'h0; ms[m] = 4'h0;
        end
        reset = 1'b1; s_ready = 1'b0; s_rdata = 32'h0;
        @(negedge clk);
        step(); step();
        reset = 1'b0;

        // Single m0 read, slave answers two cycles after s_valid.
        set_req(0, 32'h0000_0010, 32'h0, 4'b0000);
        step();
        step(); step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        step();
        s_ready = 1'b0;
        step();

        // Simultaneous requests after reset: m0, m1, then m0 again.
        reset = 1'b1; step(); reset = 1'b0;
        set_req(0, 32'h0000_0100, 32'h0, 4'b0000);
        set_req(1, 32'h0000_0200, 32'h0, 4'b0000);
        s_ready = 1'b1; s_rdata = 32'hA5A5_0001;
        repeat (5) step();
        set_req(0, 32'h0000_0104, 32'h0, 4'b0000);
        set_req(1, 32'h0000_0204, 32'h0, 4'b0000);
        step();
        check_eq("tie_alternate", 32'(grant), 32'(2'b01));
        repeat (4) step();
        s_ready = 1'b0;

        // m1 write waits behind an m0 grant.
        set_req(0, 32'h0000_0020, 32'h0, 4'b0000);
        step(); step();
        set_req(1, 32'h0200_0008, 32'h0000_00AB, 4'b0001);
        repeat (3) step();
        s_ready = 1'b1; step();
        s_ready = 1'b0; step(); step();
        s_ready = 1'b1; step();
        s_ready = 1'b0; step();

        // Reset while m1 waits on the slave.
        set_req(1, 32'h0000_0300, 32'h0, 4'b0000);
        step(); step(); step();
        reset = 1'b1; step();
        reset = 1'b0; mv[1] = 1'b0; step();

        // Stalled slave: watchdog pulse with the macro, otherwise the grant is held.
        base = rdy0_cnt;
        set_req(0, 32'h0000_0400, 32'h0, 4'b0000);
        repeat (100) step();
`ifdef PICOSOC_ARB_TIMEOUT_EN
        check_eq("stall_pulses", 32'(rdy0_cnt - base), 32'd1);
        check_eq("stall_err", 32'(timeout_err), 32'd1);
`else
        check_eq("stall_pulses", 32'(rdy0_cnt - base), 32'd0);
        check_eq("stall_err", 32'(timeout_err), 32'd0);
`endif
        s_ready = 1'b1; step();
        s_ready = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;

        // Randomized traffic with occasional protocol drops and resets.
        repeat (3000) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!mv[m] && ($urandom_range(0, 99) < 40)) begin
                    mv[m] = 1'b1;
                    ma[m] = $urandom;
                    mw[m] = $urandom;
                    ms[m] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                    mi[m] = 1'($urandom_range(0, 1));
                end
            end
            s_ready = ($urandom_range(0, 99) < 35);
            s_rdata = $urandom;
            if (!reset && own_m >= 0 && mv[own_m] && ($urandom_range(0, 99) < 3)) begin
                mv[own_m] = 1'b0;
                s_ready   = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
